// File: rtl/conv1_sched_pkg.sv
// Shared constants, state encoding and index helpers for the conv1 layer sequencer.
package conv1_pkg;

    localparam int IMG_COLS   = 26;
    localparam int ROWS       = IMG_COLS;
    localparam int DW         = 8;
    localparam int PSUM_W     = 14;
    localparam int KERNEL     = 3;
    localparam int PE_LAT     = 1;
    localparam int OUT_COLS   = IMG_COLS - KERNEL + 1;
    localparam int N_SHIFTS   = IMG_COLS + PE_LAT;
    localparam int N_KERNELS  = 4;
    localparam int TAP_W      = 4;
    localparam int COL_W      = ROWS * DW;
    localparam int WT_W       = N_KERNELS * KERNEL * TAP_W;
    localparam int PSUM_COL_W = OUT_COLS * PSUM_W;
    localparam int IDX_W      = 5;

    // Shifts before the first one whose partial sums are complete.
    localparam int FIRST_PROD = KERNEL - 1 + PE_LAT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic shift_produces(input logic [IDX_W-1:0] t);
        return (t >= IDX_W'(FIRST_PROD));
    endfunction

    function automatic logic [IDX_W-1:0] shift_to_col(input logic [IDX_W-1:0] t);
        return t - IDX_W'(FIRST_PROD);
    endfunction

endpackage

// File: rtl/conv1_sched_if.sv
// Column-buffer, PE-array and pooling-side buses of the conv1 sequencer.
interface conv1_sched_if;
    import conv1_pkg::*;

    logic                  col_rd_en;
    logic [IDX_W-1:0]      col_rd_addr;
    logic [COL_W-1:0]      col_rd_data;

    logic                  arr_en;
    logic [COL_W-1:0]      arr_ifmap;
    logic [WT_W-1:0]       arr_filtr_0;
    logic [WT_W-1:0]       arr_filtr_1;
    logic [WT_W-1:0]       arr_filtr_2;
    logic [PSUM_COL_W-1:0] psum_in_0;
    logic [PSUM_COL_W-1:0] psum_in_1;
    logic [PSUM_COL_W-1:0] psum_in_2;
    logic [PSUM_COL_W-1:0] psum_in_3;

    logic                  out_valid;
    logic [IDX_W-1:0]      out_col;
    logic [PSUM_COL_W-1:0] out_psum_0;
    logic [PSUM_COL_W-1:0] out_psum_1;
    logic [PSUM_COL_W-1:0] out_psum_2;
    logic [PSUM_COL_W-1:0] out_psum_3;

    modport master (
        output col_rd_en, col_rd_addr,
        input  col_rd_data,
        output arr_en, arr_ifmap, arr_filtr_0, arr_filtr_1, arr_filtr_2,
        input  psum_in_0, psum_in_1, psum_in_2, psum_in_3,
        output out_valid, out_col, out_psum_0, out_psum_1, out_psum_2, out_psum_3
    );

    modport slave (
        input  col_rd_en, col_rd_addr,
        output col_rd_data,
        input  arr_en, arr_ifmap, arr_filtr_0, arr_filtr_1, arr_filtr_2,
        output psum_in_0, psum_in_1, psum_in_2, psum_in_3,
        input  out_valid, out_col, out_psum_0, out_psum_1, out_psum_2, out_psum_3
    );

endinterface

// File: rtl/conv1_sched_wt_bank.sv
// Three weight tap-column registers with a loaded mask; writes accepted only while idle.
module conv1_wt_bank
    import conv1_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_allow,
    input  logic            wt_we,
    input  logic [1:0]      wt_sel,
    input  logic [WT_W-1:0] wt_data,
    output logic [WT_W-1:0] filtr_0,
    output logic [WT_W-1:0] filtr_1,
    output logic [WT_W-1:0] filtr_2,
    output logic [2:0]      mask
);

    logic [2:0][WT_W-1:0] filtr_q;
    logic [2:0][WT_W-1:0] filtr_d;
    logic [2:0]           mask_q;
    logic [2:0]           mask_d;

    // Write decode: one tap column per strobe, select 3 is a no-op.
    always_comb begin
        filtr_d = filtr_q;
        mask_d  = mask_q;
        if (wr_allow && wt_we) begin
            case (wt_sel)
                2'd0: begin
                    filtr_d[0] = wt_data;
                    mask_d[0]  = 1'b1;
                end
                2'd1: begin
                    filtr_d[1] = wt_data;
                    mask_d[1]  = 1'b1;
                end
                2'd2: begin
                    filtr_d[2] = wt_data;
                    mask_d[2]  = 1'b1;
                end
                default: begin
                    mask_d = mask_q;
                end
            endcase
        end else begin
            mask_d = mask_q;
        end
    end

    // Weight and mask storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            filtr_q <= '0;
            mask_q  <= 3'b000;
        end else begin
            filtr_q <= filtr_d;
            mask_q  <= mask_d;
        end
    end

    assign filtr_0 = filtr_q[0];
    assign filtr_1 = filtr_q[1];
    assign filtr_2 = filtr_q[2];
    assign mask    = mask_q;

endmodule

// File: rtl/conv1_sched.sv
// conv1 PE-array sequencer: issues column reads, feeds the array, flushes it with
// zero columns and registers each completed 4-kernel partial-sum column.
module conv1_sched
    import conv1_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    input  logic            wt_we,
    input  logic [1:0]      wt_sel,
    input  logic [WT_W-1:0] wt_data,
    conv1_sched_if.master   bus
);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                t_q, t_d;
    logic [2:0]                      mask;

    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    // Stage A: read/zero issue; stage B: read data in flight; stage C: array shift.
    logic                            rd_en_q, rd_en_d;
    logic [IDX_W-1:0]                rd_addr_q, rd_addr_d;
    logic                            zero_q, zero_d;
    logic                            b_vld_q, b_vld_d;
    logic                            b_zero_q, b_zero_d;
    logic [IDX_W-1:0]                b_idx_q, b_idx_d;
    logic                            arr_en_q, arr_en_d;
    logic [COL_W-1:0]                col_q, col_d;
    logic [IDX_W-1:0]                c_idx_q, c_idx_d;

    logic                            cap_q, cap_d;
    logic [IDX_W-1:0]                cap_col_q, cap_col_d;
    logic                            out_valid_q, out_valid_d;
    logic [IDX_W-1:0]                out_col_q, out_col_d;
    logic [N_KERNELS-1:0][PSUM_COL_W-1:0] out_psum_q, out_psum_d;

    logic                            start_ok;
    logic                            last_out;

    // Start is judged against the mask as it stood before any same-cycle write.
    assign start_ok = start && (mask == 3'b111);
    assign last_out = out_valid_q && (out_col_q == IDX_W'(OUT_COLS - 1));

    conv1_wt_bank u_wt_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_allow (state_q == ST_IDLE),
        .wt_we    (wt_we),
        .wt_sel   (wt_sel),
        .wt_data  (wt_data),
        .filtr_0  (bus.arr_filtr_0),
        .filtr_1  (bus.arr_filtr_1),
        .filtr_2  (bus.arr_filtr_2),
        .mask     (mask)
    );

    // FSM state and shift-index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // FSM next state; t_q is the shift being issued while in RUN/FLUSH.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    t_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                t_d = t_q + IDX_W'(1);
                if (t_q == IDX_W'(IMG_COLS - 1)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                t_d = t_q + IDX_W'(1);
                if (t_q == IDX_W'(N_SHIFTS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (last_out) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Output/pipeline next values, decoded from the next state so outputs are registered.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_DRAIN) && last_out;
        err_d   = (state_q == ST_IDLE) && start && (mask != 3'b111);

        rd_en_d = (state_d == ST_RUN);
        zero_d  = (state_d == ST_FLUSH);
        if (state_d == ST_RUN) begin
            rd_addr_d = t_d;
        end else begin
            rd_addr_d = rd_addr_q;
        end

        b_vld_d  = rd_en_q || zero_q;
        b_zero_d = zero_q;
        b_idx_d  = t_q;

        arr_en_d = b_vld_q;
        c_idx_d  = b_idx_q;
        if (b_vld_q) begin
            col_d = b_zero_q ? '0 : bus.col_rd_data;
        end else begin
            col_d = col_q;
        end

        cap_d     = arr_en_q && shift_produces(c_idx_q);
        cap_col_d = shift_to_col(c_idx_q);

        out_valid_d = cap_q;
        if (cap_q) begin
            out_col_d  = cap_col_q;
            out_psum_d = {bus.psum_in_3, bus.psum_in_2, bus.psum_in_1, bus.psum_in_0};
        end else begin
            out_col_d  = out_col_q;
            out_psum_d = out_psum_q;
        end
    end

    // Registered outputs and issue/capture pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            zero_q      <= 1'b0;
            b_vld_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            b_idx_q     <= '0;
            arr_en_q    <= 1'b0;
            col_q       <= '0;
            c_idx_q     <= '0;
            cap_q       <= 1'b0;
            cap_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_psum_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            zero_q      <= zero_d;
            b_vld_q     <= b_vld_d;
            b_zero_q    <= b_zero_d;
            b_idx_q     <= b_idx_d;
            arr_en_q    <= arr_en_d;
            col_q       <= col_d;
            c_idx_q     <= c_idx_d;
            cap_q       <= cap_d;
            cap_col_q   <= cap_col_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_psum_q  <= out_psum_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign bus.col_rd_en   = rd_en_q;
    assign bus.col_rd_addr = rd_addr_q;
    assign bus.arr_en      = arr_en_q;
    assign bus.arr_ifmap   = col_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_col     = out_col_q;
    assign bus.out_psum_0  = out_psum_q[0];
    assign bus.out_psum_1  = out_psum_q[1];
    assign bus.out_psum_2  = out_psum_q[2];
    assign bus.out_psum_3  = out_psum_q[3];

endmodule

// File: doc/conv1_sched.md
# conv1_sched

Sequencer for the first convolution layer's PE array (four kernels, 3×3 taps, 26-row columns). It does four things:
- holds the three weight tap columns;
- streams input-feature-map columns from the column buffer into the array, gating `arr_en`;
- flushes the array pipeline with zero columns;
- registers each valid 4-kernel partial-sum column for the pooling stage.

It sits between the ifmap column buffer and the conv1 array, and it is the only driver of the array's enable, data and weight inputs.

## Interface
- `IMG_COLS`, 26, input columns per image (= rows, `ROWS`).
- `DW`, 8, pixel width.
- `PSUM_W`, 14, partial-sum width per output pixel.
- `PE_LAT`, 1, enabled shifts from the completing column to a stable `psum`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one image, sampled in IDLE.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse at the end of an image.
- `err` out 1: one-cycle pulse when start is rejected.
- `wt_we` in 1: weight write strobe.
- `wt_sel` in 2: tap column to write (0, 1 or 2; 3 is ignored).
- `wt_data` in 48: four kernels × 3 taps × 4 b.
- `col_rd_en` out 1: column-buffer read strobe.
- `col_rd_addr` out 5: column-buffer read address.
- `col_rd_data` in 208: read data, valid the cycle after `col_rd_en`.
- `arr_en` out 1: array enable (one shift per cycle high).
- `arr_ifmap` out 208: column presented to the array.
- `arr_filtr_0` / `arr_filtr_1` / `arr_filtr_2` out 48 each: weight columns.
- `psum_in_0` … `psum_in_3` in 336 each: array outputs, 24 × `PSUM_W`.
- `out_valid` out 1: registered output column valid.
- `out_col` out 5: output column index, 0..23.
- `out_psum_0` … `out_psum_3` out 336 each: registered partial sums.

## Operation
- **Weights**
  - `wt_we` in IDLE with `wt_sel` < 3 loads `arr_filtr_<wt_sel>` and sets bit `wt_sel` of a 3-bit loaded mask.
  - `wt_we` outside IDLE, or with `wt_sel` = 3, is ignored.
  - Weights persist across images; only `rst` clears them and the mask.
- **Start**
  - `start` in IDLE with mask = 3'b111 is accepted and moves the FSM to RUN.
  - `start` in IDLE with the mask incomplete pulses `err` the next cycle and stays in IDLE.
  - `start` while busy is ignored, with no `err`.
  - `start` and `wt_we` in the same IDLE cycle: the write takes effect, and start is evaluated against the mask before that write.
- **States:** IDLE → RUN → FLUSH → DRAIN → IDLE.
  - RUN issues reads for columns 0..`IMG_COLS`-1, one per cycle, with `col_rd_addr` equal to the shift index.
  - FLUSH issues `PE_LAT` zero shifts with no read.
  - DRAIN waits for the last shift to emit its output, then pulses `done` and returns to IDLE.
- **Shifts**
  - Shift index t runs 0..`IMG_COLS`+`PE_LAT`-1, i.e. 27 shifts at the defaults.
  - Read data is captured into an internal column register, which drives `arr_ifmap`.
  - For zero shifts the column register is loaded with 0.
  - Shift t with t ≥ 2+`PE_LAT` produces output column j = t−2−`PE_LAT`.
- **Output capture**
  - The cycle after a producing shift, all `psum_in_*` are captured into `out_psum_*`, with `out_col` = j.
  - `out_valid` is high for exactly one cycle per column, 24 columns per image, and j strictly increases.
  - There is no backpressure: downstream accepts every `out_valid`.
- **Mid-image reset:** `rst` asserted mid-image aborts the image with no `done`, and all state returns to reset values on the next edge.

## Timing
- **Reset values:**
  - `busy`, `done`, `err`, `col_rd_en`, `arr_en`, `out_valid` = 0;
  - `col_rd_addr`, `out_col` = 0;
  - `arr_ifmap`, `arr_filtr_*`, `out_psum_*` = 0;
  - mask = 0, state = IDLE.
- **Schedule** (start accepted at cycle S):
  - `busy` rises at S+1.
  - Read for t issued at S+1+t, for t < 26.
  - `arr_en` high at S+3+t, for t = 0..26, contiguous (S+3 .. S+29).
  - `out_valid` for column j at S+5+(j+2+`PE_LAT`): j = 0 at S+8, j = 23 at S+31.
  - `done` pulses at S+32, `busy` falls at S+32, and IDLE accepts a new `start` at S+32.
- **Holding:** `arr_ifmap` holds its last value whenever `arr_en` = 0.
- **Weights in flight:** `arr_filtr_*` are stable throughout busy.

## Structure
- **Package `conv1_pkg`:**
  - constants `IMG_COLS`, `ROWS`, `DW`, `PSUM_W`, `KERNEL` = 3;
  - `OUT_COLS` = `IMG_COLS`−`KERNEL`+1;
  - the state enum (IDLE / RUN / FLUSH / DRAIN).
- **Sub-module `conv1_wt_bank`:** the three 48-bit registers plus the loaded mask and the write-enable gating.
- **Top level:** the FSM, the shift counter, the 2-stage issue pipeline and the output registers stay in `conv1_sched`.

## Test plan
- Reset, then `start` with no weights written → `err` pulse one cycle later, `busy` stays 0, no `col_rd_en`.
- Load weights 12'h111 in every tap of every kernel (`wt_data` = 48'h111111111111, sel 0/1/2), buffer column c filled with pixel value c → `arr_en` high for 27 contiguous cycles, `col_rd_addr` 0..25, then one zero column; 24 `out_valid` pulses, `out_col` 0..23, first pulse at S+8; `done` at S+32.
- Scoreboard: array model plus golden 3×3 convolution on random 26×26 image and random weights → `out_psum_0..3` match for all 24 columns.
- `start` pulsed at S+10 and `wt_we` (sel 1, 48'hFFFF…) at S+12 during the image → both ignored, `arr_filtr_1` unchanged, exactly one `done`.
- `rst` asserted at S+15 → next cycle all outputs at reset values, mask 0; a subsequent `start` gives `err`.
- Back-to-back: `start` at S+32 → second image begins (`busy` at S+33) with no gap in ordering; 48 total `out_valid`, 2 `done`.
